frame_buffer_scheduler: RTL and testbench
=========================================

# frame_buffer_scheduler

Ping-pong frame-buffer scheduler for the output pipeline. Owns the two 32K-word halves of frame memory (selected by address bit 15): it hands one half to the processing pipeline for writing while the other is streamed out by the output fetch stage, and swaps roles at frame boundaries. It drives the fetch stage's `start` and `output_base_offset`, consumes its `done`, and back-pressures the processing pipeline when both halves are full.

## Interface
Parameters:
- `GAP_CYCLES`, default 8: minimum cycles `out_start` is held low between frames (covers the fetch stage's 6-cycle `done` pipeline plus address reload).
- `FRAME_COUNT_W`, default 16: width of `frame_count`.

Ports:
- `clock`  in  1: clock.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `enable`  in  1: level; allows new output frames to begin.
- `proc_frame_done`  in  1: single-cycle pulse; processing pipeline finished writing the half selected by `write_base_offset`.
- `out_done`  in  1: level from the output fetch stage; frame fully emitted.
- `proc_ready`  out  1: write half is free; processing may write.
- `write_base_offset`  out  1: address bit 15 for the processing writer.
- `out_start`  out  1: level start to the output fetch stage.
- `output_base_offset`  out  1: address bit 15 for the output fetch stage.
- `frame_count`  out  FRAME_COUNT_W: frames completed, wraps modulo 2^FRAME_COUNT_W.
- `overrun`  out  1: sticky; `proc_frame_done` arrived while `proc_ready` was low.
- `busy`  out  1: high in OUTPUT or GAP.

## Operation
- State: `wr_sel`, `rd_sel`, `buf_full[1:0]`, FSM {IDLE, WAIT, OUTPUT, GAP}, gap counter, `out_done_q`.
- `proc_ready` = registered `!buf_full[wr_sel]`; `write_base_offset` = `wr_sel`.
- `proc_frame_done` with `proc_ready` high: set `buf_full[wr_sel]`, toggle `wr_sel`. With `proc_ready` low: frame dropped, no state change, `overrun` set until reset.
- IDLE: `enable` high -> WAIT.
- WAIT: `enable` low -> IDLE. Else if `buf_full[rd_sel]` -> OUTPUT; `output_base_offset` <= `rd_sel`, `out_start` <= 1.
- OUTPUT: act only on the `out_done` rising edge (`out_done & !out_done_q`). On that edge: `out_start` <= 0, clear `buf_full[rd_sel]`, toggle `rd_sel`, increment `frame_count`, load gap counter, -> GAP. Deasserting `enable` never aborts a frame.
- GAP: `out_start` low for `GAP_CYCLES` cycles, then -> WAIT. `output_base_offset` holds its value through GAP.
- Simultaneous release (OUTPUT edge) and `proc_frame_done` in the same cycle: `proc_ready` is registered, so the pulse is judged against the pre-release value. If the writer was blocked, this is an overrun.
- Reset mid-frame: all state returns to reset values immediately. The fetch stage sees `start` low and reloads its address.

## Timing
- Reset values: `out_start` 0, `output_base_offset` 0, `write_base_offset` 0, `proc_ready` 1, `frame_count` 0, `overrun` 0, `busy` 0, FSM IDLE, `buf_full` 00.
- `proc_frame_done` sampled at edge k: `proc_ready` and `write_base_offset` update after edge k+1. Earliest `out_start` rise (FSM in WAIT) is after edge k+2.
- `out_done` rising edge sampled at edge n: `out_start` low after edge n+1. Earliest re-rise is after edge n+GAP_CYCLES+2.
- `out_done` held high across frames never re-triggers; a low cycle is required before the next edge.

## Structure
- Shared package `output_pkg`: FSM state enum, `BUF_A`=1'b0 / `BUF_B`=1'b1, default `GAP_CYCLES`.
- Single module; the `out_done` edge detect is inline. No sub-module.

## Test plan
- Reset, `enable`=1, one `proc_frame_done` -> `out_start`=1 two cycles later, `output_base_offset`=0, `write_base_offset`=1, `proc_ready`=1.
- Pulse `out_done` high during OUTPUT -> `out_start` low, `frame_count`=1, `out_start` stays low ≥8 cycles, FSM returns to WAIT, no restart while `buf_full`=00.
- Three `proc_frame_done` pulses before any output completes -> third sets `overrun`=1; `proc_ready`=0 after the second.
- Hold `out_done` high continuously for 50 cycles after completion, with a new frame ready -> exactly one `frame_count` increment. The new frame starts with `output_base_offset`=1.
- Drop `enable` mid-OUTPUT -> frame completes on `out_done`, FSM goes GAP then IDLE, no further `out_start`.
- Assert `reset_n`=0 mid-OUTPUT -> all outputs at reset values asynchronously. Run 2^16+1 frames -> `frame_count` wraps to 1.

Source files
------------

// File: rtl/output_pkg.sv
// Shared definitions for the output pipeline: frame-buffer scheduler state
// encoding, half-buffer names and the default inter-frame gap.
package output_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OUTPUT = 2'd2,
    ST_GAP    = 2'd3
  } fbs_state_e;

  // Half-buffer selectors: the value driven on frame-memory address bit 15.
  localparam logic BUF_A = 1'b0;
  localparam logic BUF_B = 1'b1;

  // Covers the fetch stage's 6-cycle done pipeline plus its address reload.
  localparam int unsigned GAP_CYCLES_DEFAULT = 8;

  // The half that is not `sel`; ping-pong roles always alternate.
  function automatic logic other_buf(input logic sel);
    return (sel == BUF_A) ? BUF_B : BUF_A;
  endfunction

endpackage

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame-buffer scheduler. One half of frame memory is handed to the
// processing writer while the other is streamed out by the fetch stage; the
// roles swap at frame boundaries. All outputs are registered.
module frame_buffer_scheduler
  import output_pkg::*;
#(
  parameter int unsigned GAP_CYCLES    = GAP_CYCLES_DEFAULT,
  parameter int unsigned FRAME_COUNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     proc_frame_done,
  input  logic                     out_done,
  output logic                     proc_ready,
  output logic                     write_base_offset,
  output logic                     out_start,
  output logic                     output_base_offset,
  output logic [FRAME_COUNT_W-1:0] frame_count,
  output logic                     overrun,
  output logic                     busy
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  // GAP is entered with GAP_CYCLES-1 and left when the counter reads zero,
  // giving exactly GAP_CYCLES cycles in GAP.
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  fbs_state_e               state_q, state_d;
  logic [GAP_W-1:0]         gap_cnt_q, gap_cnt_d;
  logic                     wr_sel_q, wr_sel_d;
  logic                     rd_sel_q, rd_sel_d;
  logic [1:0]               buf_full_q, buf_full_d;
  logic                     accept_pend_q, accept_pend_d;
  logic                     proc_ready_q, proc_ready_d;
  logic                     out_start_q, out_start_d;
  logic                     output_base_offset_q, output_base_offset_d;
  logic [FRAME_COUNT_W-1:0] frame_count_q, frame_count_d;
  logic                     overrun_q, overrun_d;
  logic                     busy_q, busy_d;
  logic                     out_done_q;
  logic                     out_done_prev_q;

  logic                     out_done_rise;
  logic                     release_buf;

  // out_done is a level; only its low-to-high transition ends a frame, so a
  // level held across frames cannot re-trigger.
  assign out_done_rise = out_done_q & ~out_done_prev_q;

  // Output-side sequencing: wait for a full half, stream it, then hold start
  // low for the gap so the fetch stage can drain and reload its address.
  always_comb begin
    state_d              = state_q;
    gap_cnt_d            = gap_cnt_q;
    out_start_d          = out_start_q;
    output_base_offset_d = output_base_offset_q;
    release_buf          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (buf_full_q[rd_sel_q]) begin
          state_d              = ST_OUTPUT;
          out_start_d          = 1'b1;
          output_base_offset_d = rd_sel_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_OUTPUT: begin
        // enable is deliberately ignored here: a started frame always completes.
        if (out_done_rise) begin
          state_d     = ST_GAP;
          out_start_d = 1'b0;
          gap_cnt_d   = GAP_LOAD;
          release_buf = 1'b1;
        end else begin
          state_d = ST_OUTPUT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == {GAP_W{1'b0}}) begin
          state_d = ST_WAIT;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_start_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_OUTPUT) || (state_d == ST_GAP);
  end

  // Buffer ownership: a writer completion is judged against the registered
  // proc_ready it could see, then committed one cycle later; a release frees
  // the read half and advances the frame counter.
  always_comb begin
    buf_full_d    = buf_full_q;
    wr_sel_d      = wr_sel_q;
    rd_sel_d      = rd_sel_q;
    frame_count_d = frame_count_q;
    overrun_d     = overrun_q;
    accept_pend_d = 1'b0;
    if (proc_frame_done) begin
      if (proc_ready_q) begin
        accept_pend_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      accept_pend_d = 1'b0;
    end
    if (release_buf) begin
      buf_full_d[rd_sel_q] = 1'b0;
      rd_sel_d             = other_buf(rd_sel_q);
      frame_count_d        = frame_count_q + FRAME_COUNT_W'(1);
    end else begin
      rd_sel_d = rd_sel_q;
    end
    if (accept_pend_q) begin
      buf_full_d[wr_sel_q] = 1'b1;
      wr_sel_d             = other_buf(wr_sel_q);
    end else begin
      wr_sel_d = wr_sel_q;
    end
    proc_ready_d = ~buf_full_d[wr_sel_d];
  end

  // State and output registers; reset returns everything to an idle, empty
  // scheduler so the fetch stage sees start low immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= ST_IDLE;
      gap_cnt_q            <= {GAP_W{1'b0}};
      wr_sel_q             <= BUF_A;
      rd_sel_q             <= BUF_A;
      buf_full_q           <= 2'b00;
      accept_pend_q        <= 1'b0;
      proc_ready_q         <= 1'b1;
      out_start_q          <= 1'b0;
      output_base_offset_q <= BUF_A;
      frame_count_q        <= {FRAME_COUNT_W{1'b0}};
      overrun_q            <= 1'b0;
      busy_q               <= 1'b0;
      out_done_q           <= 1'b0;
      out_done_prev_q      <= 1'b0;
    end else begin
      state_q              <= state_d;
      gap_cnt_q            <= gap_cnt_d;
      wr_sel_q             <= wr_sel_d;
      rd_sel_q             <= rd_sel_d;
      buf_full_q           <= buf_full_d;
      accept_pend_q        <= accept_pend_d;
      proc_ready_q         <= proc_ready_d;
      out_start_q          <= out_start_d;
      output_base_offset_q <= output_base_offset_d;
      frame_count_q        <= frame_count_d;
      overrun_q            <= overrun_d;
      busy_q               <= busy_d;
      out_done_q           <= out_done;
      out_done_prev_q      <= out_done_q;
    end
  end

  assign proc_ready         = proc_ready_q;
  assign write_base_offset  = wr_sel_q;
  assign out_start          = out_start_q;
  assign output_base_offset = output_base_offset_q;
  assign frame_count        = frame_count_q;
  assign overrun            = overrun_q;
  assign busy               = busy_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Self-checking bench for frame_buffer_scheduler. A reference model views the
// two halves as a 2-deep queue of finished frames (writer pushes, output pops)
// and tracks the output schedule by cycle numbers.
module tb_frame_buffer_scheduler;

  localparam int GAP = 8;
  localparam int FCW = 5;

  logic           clock = 1'b0;
  logic           reset_n;
  logic           enable;
  logic           proc_frame_done;
  logic           out_done;
  logic           proc_ready;
  logic           write_base_offset;
  logic           out_start;
  logic           output_base_offset;
  logic [FCW-1:0] frame_count;
  logic           overrun;
  logic           busy;

  frame_buffer_scheduler #(.GAP_CYCLES(GAP), .FRAME_COUNT_W(FCW)) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .enable             (enable),
    .proc_frame_done    (proc_frame_done),
    .out_done           (out_done),
    .proc_ready         (proc_ready),
    .write_base_offset  (write_base_offset),
    .out_start          (out_start),
    .output_base_offset (output_base_offset),
    .frame_count        (frame_count),
    .overrun            (overrun),
    .busy               (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  bit q[$];          // halves holding finished frames, oldest first
  int accepted;      // frames accepted from the writer
  int completed;     // frames fully emitted
  bit pend;          // accepted frame not yet committed
  bit ready_m, overrun_m;
  bit od_s, od_p;    // out_done as seen at the last two edges
  bit outputting, armed;
  int gap_until;     // edge number at which the gap ends
  bit obo_m;
  int cyc;

  task automatic model_reset();
    q.delete();
    accepted = 0; completed = 0; pend = 0;
    ready_m = 1; overrun_m = 0; od_s = 0; od_p = 0;
    outputting = 0; armed = 0; gap_until = -1; obo_m = 0; cyc = 0;
  endtask

  task automatic model_edge(input bit en, input bit pfd, input bit od);
    bit acc_now;
    bit rel;
    cyc++;
    acc_now = pfd && ready_m;
    if (pfd && !ready_m) overrun_m = 1;
    rel = 0;
    if (outputting) begin
      if (od_s && !od_p) begin
        rel = 1; outputting = 0; gap_until = cyc + GAP;
      end
    end else if (cyc == gap_until) begin
      armed = 1;
    end else if (cyc > gap_until) begin
      if (!armed) armed = en;
      else if (!en) armed = 0;
      else if (q.size() > 0) begin
        outputting = 1; obo_m = q[0];
      end
    end
    if (rel) begin
      void'(q.pop_front());
      completed++;
    end
    if (pend) begin
      q.push_back(bit'(accepted % 2));
      accepted++;
    end
    pend = acc_now;
    ready_m = (q.size() < 2);
    od_p = od_s;
    od_s = od;
  endtask

  task automatic compare_all();
    check_eq("out_start", int'(out_start), int'(outputting));
    check_eq("output_base_offset", int'(output_base_offset), int'(obo_m));
    check_eq("write_base_offset", int'(write_base_offset), accepted % 2);
    check_eq("proc_ready", int'(proc_ready), int'(ready_m));
    check_eq("frame_count", int'(frame_count), completed % (1 << FCW));
    check_eq("overrun", int'(overrun), int'(overrun_m));
    check_eq("busy", int'(busy), int'(outputting || (cyc < gap_until)));
  endtask

  task automatic step(input bit en, input bit pfd, input bit od);
    enable = en; proc_frame_done = pfd; out_done = od;
    @(posedge clock);
    model_edge(en, pfd, od);
    #1;
    compare_all();
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (out_start !== 1'b1 && n < 40) begin
      step(1'b1, 1'b0, 1'b0);
      n++;
    end
    check_eq(tag, int'(out_start), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_out_start"}, int'(out_start), 0);
    check_eq({tag, "_obo"}, int'(output_base_offset), 0);
    check_eq({tag, "_wbo"}, int'(write_base_offset), 0);
    check_eq({tag, "_ready"}, int'(proc_ready), 1);
    check_eq({tag, "_fc"}, int'(frame_count), 0);
    check_eq({tag, "_overrun"}, int'(overrun), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    bit en_r, pfd_r, od_r, last_pfd;

    reset_n = 1'b0; enable = 1'b0; proc_frame_done = 1'b0; out_done = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #3 reset_n = 1'b1;
    #1 check_reset_values("reset");

    // One writer completion starts the first frame two edges later.
    step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    check_eq("start_not_early", int'(out_start), 0);
    step(1, 0, 0);
    check_eq("start_rise", int'(out_start), 1);
    check_eq("start_obo", int'(output_base_offset), 0);
    check_eq("start_wbo", int'(write_base_offset), 1);
    check_eq("start_ready", int'(proc_ready), 1);

    // out_done rises and is then held high for 50 cycles; a new frame
    // becomes ready during the gap and must start without a second count.
    step(1, 0, 1);
    step(1, 0, 1);
    check_eq("done_start_low", int'(out_start), 0);
    check_eq("done_fc", int'(frame_count), 1);
    for (int i = 0; i < 50; i++) step(1, (i == 3), 1);
    check_eq("held_fc", int'(frame_count), 1);
    check_eq("held_restart", int'(out_start), 1);
    check_eq("held_obo", int'(output_base_offset), 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    repeat (12) step(1, 0, 0);
    check_eq("empty_no_restart", int'(out_start), 0);
    check_eq("empty_fc", int'(frame_count), 2);

    // Three completions before any output finishes: the third overruns.
    step(1, 1, 0); step(1, 0, 0);
    step(1, 1, 0); step(1, 0, 0);
    check_eq("two_full_ready", int'(proc_ready), 0);
    check_eq("no_overrun_yet", int'(overrun), 0);
    step(1, 1, 0); step(1, 0, 0);
    check_eq("third_overrun", int'(overrun), 1);
    for (int f = 0; f < 2; f++) begin
      wait_start("drain_start");
      step(1, 0, 1);
      step(1, 0, 0);
    end
    repeat (12) step(1, 0, 0);
    check_eq("drain_fc", int'(frame_count), 4);

    // enable drops mid-frame: the frame still completes, nothing restarts.
    step(1, 1, 0);
    wait_start("en_drop_start");
    repeat (3) step(0, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    repeat (20) step(0, 0, 0);
    check_eq("en_drop_start_low", int'(out_start), 0);
    check_eq("en_drop_idle", int'(busy), 0);
    check_eq("en_drop_fc", int'(frame_count), 5);

    // Reset while a frame is being emitted.
    step(1, 0, 0);
    wait_start("pre_reset_start");
    #2 reset_n = 1'b0;
    #1 check_reset_values("mid_reset");
    model_reset();
    @(posedge clock);
    #3 reset_n = 1'b1;

    // Frame counter wraps after 2^FCW + 1 frames.
    for (int f = 0; f < (1 << FCW) + 1; f++) begin
      step(1, 1, 0);
      wait_start("wrap_start");
      step(1, 0, 1);
      step(1, 0, 0);
    end
    repeat (12) step(1, 0, 0);
    check_eq("wrap_fc", int'(frame_count), 1);

    // Randomized traffic; writer pulses never land on consecutive cycles.
    last_pfd = 0;
    od_r = 0;
    for (int i = 0; i < 4000; i++) begin
      en_r  = ($urandom_range(0, 9) != 0);
      pfd_r = !last_pfd && ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) od_r = !od_r;
      step(en_r, pfd_r, od_r);
      last_pfd = pfd_r;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
